// File: rtl/instr_dispatch_if.sv
// rtl/instr_dispatch_if.sv - fetch, load/compute issue and status signals of instr_dispatch
//
// Signal groups:
//   fetch strobe   : i_instr[63:0], i_instr_addr[4:0], i_instr_enable
//   load unit      : ld_valid/ld_ready, ld_done
//   compute unit   : cp_valid/cp_ready
//   shared payload : uop_opcode[7:0], uop_addr[23:0], uop_mem_id[7:0], uop_param[23:0], uop_index[4:0]
//   status         : fifo_count[2:0], fifo_full, done, err[2:0]
// slave is the dispatch stage side, master is the environment side.

interface instr_dispatch_if;
    logic [63:0] i_instr;
    logic [4:0]  i_instr_addr;
    logic        i_instr_enable;

    logic        ld_valid;
    logic        ld_ready;
    logic        ld_done;
    logic        cp_valid;
    logic        cp_ready;

    logic [7:0]  uop_opcode;
    logic [23:0] uop_addr;
    logic [7:0]  uop_mem_id;
    logic [23:0] uop_param;
    logic [4:0]  uop_index;

    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        done;
    logic [2:0]  err;

    modport slave (
        input  i_instr, i_instr_addr, i_instr_enable,
        input  ld_ready, ld_done, cp_ready,
        output ld_valid, cp_valid,
        output uop_opcode, uop_addr, uop_mem_id, uop_param, uop_index,
        output fifo_count, fifo_full, done, err
    );

    modport master (
        output i_instr, i_instr_addr, i_instr_enable,
        output ld_ready, ld_done, cp_ready,
        input  ld_valid, cp_valid,
        input  uop_opcode, uop_addr, uop_mem_id, uop_param, uop_index,
        input  fifo_count, fifo_full, done, err
    );
endinterface

// File: rtl/instr_dispatch.sv
// rtl/instr_dispatch.sv - instruction FIFO, decode and load/compute issue with load ordering
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_dispatch_if.slave (fetch strobe in, load/compute handshakes out,
//              decoded uop payload, FIFO occupancy, sticky done and err flags)
// err bits: [2] ld_done with no outstanding load, [1] illegal opcode, [0] FIFO overflow.

module instr_dispatch #(
    parameter int DEPTH  = 4,
    parameter int MAX_LD = 15
) (
    input  logic             clk,
    input  logic             rst,
    instr_dispatch_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LDW = $clog2(MAX_LD + 1);
    localparam logic [AW:0]    DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [LDW-1:0] MAX_LD_C = LDW'(MAX_LD);

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_COMPUTE,
        CLS_LOAD,
        CLS_END,
        CLS_ILLEGAL
    } op_class_e;

    // FIFO entry: {index[4:0], word[63:0]}
    logic [68:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;

    logic           iss_valid;
    logic           iss_is_load;
    logic [7:0]     iss_opcode;
    logic [23:0]    iss_addr;
    logic [7:0]     iss_mem_id;
    logic [23:0]    iss_param;
    logic [4:0]     iss_index;

    logic [LDW-1:0] ld_cnt;
    logic           done_q;
    logic [2:0]     err_q;

    logic [68:0]    head;
    op_class_e      head_cls;
    logic           fifo_empty, fifo_full;
    logic           ld_fire, cp_fire, slot_free;
    logic           pop, load_iss, set_done, set_ill;
    logic           push, drop;
    logic           ld_valid_c, cp_valid_c;

    always_comb begin
        head       = mem[rd_ptr];
        fifo_empty = (count == '0);
        fifo_full  = (count == DEPTH_C);

        unique case (head[63:56])
            8'h00:               head_cls = CLS_NOP;
            8'h01, 8'h02:        head_cls = CLS_COMPUTE;
            8'h03, 8'h04, 8'h05: head_cls = CLS_LOAD;
            8'hFF:               head_cls = CLS_END;
            default:             head_cls = CLS_ILLEGAL;
        endcase
    end

    // Loads stall only when the outstanding counter is saturated; compute waits
    // until every issued load has reported completion.
    assign ld_valid_c = iss_valid &&  iss_is_load && (ld_cnt != MAX_LD_C);
    assign cp_valid_c = iss_valid && !iss_is_load && (ld_cnt == '0);
    assign ld_fire    = ld_valid_c && bus.ld_ready;
    assign cp_fire    = cp_valid_c && bus.cp_ready;
    assign slot_free  = !iss_valid || ld_fire || cp_fire;

    always_comb begin
        pop      = 1'b0;
        load_iss = 1'b0;
        set_done = 1'b0;
        set_ill  = 1'b0;
        if (!fifo_empty && !done_q) begin
            unique case (head_cls)
                CLS_NOP: pop = 1'b1;
                CLS_ILLEGAL: begin
                    pop     = 1'b1;
                    set_ill = 1'b1;
                end
                CLS_END: begin
                    // END retires only once all prior work has drained.
                    if (!iss_valid && ld_cnt == '0) begin
                        pop      = 1'b1;
                        set_done = 1'b1;
                    end
                end
                default: begin
                    if (slot_free) begin
                        pop      = 1'b1;
                        load_iss = 1'b1;
                    end
                end
            endcase
        end
    end

    // A pop in the same cycle frees the slot for an incoming word on a full FIFO.
    assign push = bus.i_instr_enable && (!fifo_full || pop);
    assign drop = bus.i_instr_enable && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.i_instr_addr, bus.i_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            iss_valid   <= 1'b0;
            iss_is_load <= 1'b0;
            iss_opcode  <= '0;
            iss_addr    <= '0;
            iss_mem_id  <= '0;
            iss_param   <= '0;
            iss_index   <= '0;
            ld_cnt      <= '0;
            done_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase

            if (load_iss) begin
                iss_valid   <= 1'b1;
                iss_is_load <= (head_cls == CLS_LOAD);
                iss_opcode  <= head[63:56];
                iss_addr    <= head[55:32];
                iss_mem_id  <= head[31:24];
                iss_param   <= head[23:0];
                iss_index   <= head[68:64];
            end else if (ld_fire || cp_fire) begin
                iss_valid   <= 1'b0;
            end

            case ({ld_fire, bus.ld_done})
                2'b10:   ld_cnt <= ld_cnt + LDW'(1);
                2'b01: begin
                    if (ld_cnt != '0) ld_cnt <= ld_cnt - LDW'(1);
                    else              err_q[2] <= 1'b1;
                end
                default: ld_cnt <= ld_cnt;
            endcase

            if (set_ill)  err_q[1] <= 1'b1;
            if (drop)     err_q[0] <= 1'b1;
            if (set_done) done_q   <= 1'b1;
        end
    end

    assign bus.ld_valid   = ld_valid_c;
    assign bus.cp_valid   = cp_valid_c;
    assign bus.uop_opcode = iss_opcode;
    assign bus.uop_addr   = iss_addr;
    assign bus.uop_mem_id = iss_mem_id;
    assign bus.uop_param  = iss_param;
    assign bus.uop_index  = iss_index;
    assign bus.fifo_count = count;
    assign bus.fifo_full  = fifo_full;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// tb/tb_instr_dispatch.sv - directed self-checking bench for instr_dispatch

module tb_instr_dispatch;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   stuck;
    logic both_seen;
    logic [12:0] issue_log [$];

    instr_dispatch_if bus ();

    instr_dispatch #(.DEPTH(4), .MAX_LD(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted issue as {opcode, index}.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ld_valid && bus.cp_valid) both_seen = 1'b1;
            if ((bus.ld_valid && bus.ld_ready) || (bus.cp_valid && bus.cp_ready))
                issue_log.push_back({bus.uop_opcode, bus.uop_index});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] w, input logic [4:0] idx);
        bus.i_instr        = w;
        bus.i_instr_addr   = idx;
        bus.i_instr_enable = 1'b1;
        tick();
        bus.i_instr_enable = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_ld_valid"},   bus.ld_valid,   1'b0);
        check({pfx, "_cp_valid"},   bus.cp_valid,   1'b0);
        check({pfx, "_uop_opcode"}, bus.uop_opcode, 8'h00);
        check({pfx, "_uop_index"},  bus.uop_index,  5'd0);
        check({pfx, "_fifo_count"}, bus.fifo_count, 3'd0);
        check({pfx, "_fifo_full"},  bus.fifo_full,  1'b0);
        check({pfx, "_done"},       bus.done,       1'b0);
        check({pfx, "_err"},        bus.err,        3'b000);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        both_seen = 1'b0;
        rst                = 1'b1;
        bus.i_instr        = '0;
        bus.i_instr_addr   = '0;
        bus.i_instr_enable = 1'b0;
        bus.ld_ready       = 1'b1;
        bus.cp_ready       = 1'b1;
        bus.ld_done        = 1'b0;

        do_reset();
        check_reset_state("rst");

        // Single LOAD_FEATURE: 2-edge latency, one-cycle ld_valid.
        push(64'h0400000001000000, 5'd7);
        check("t1_count_after_write", bus.fifo_count, 3'd1);
        check("t1_no_early_valid",    bus.ld_valid,   1'b0);
        tick();
        check("t1_ld_valid",   bus.ld_valid,   1'b1);
        check("t1_cp_valid",   bus.cp_valid,   1'b0);
        check("t1_opcode",     bus.uop_opcode, 8'h04);
        check("t1_mem_id",     bus.uop_mem_id, 8'h01);
        check("t1_addr",       bus.uop_addr,   24'h0);
        check("t1_param",      bus.uop_param,  24'h0);
        check("t1_index",      bus.uop_index,  5'd7);
        check("t1_fifo_empty", bus.fifo_count, 3'd0);
        tick();
        check("t1_ld_valid_drop", bus.ld_valid, 1'b0);
        bus.ld_done = 1'b1;
        tick();
        bus.ld_done = 1'b0;
        check("t1_no_err", bus.err, 3'b000);

        // LOAD then CONV: CONV held until the load completes.
        issue_log.delete();
        push(64'h0400000001000000, 5'd1);
        push(64'h0100000000000010, 5'd2);
        stuck = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cp_valid) stuck++;
        end
        check("t2_cp_held", stuck, 0);
        bus.ld_done = 1'b1;
        tick();
        bus.ld_done = 1'b0;
        check("t2_cp_valid",  bus.cp_valid,   1'b1);
        check("t2_cp_param",  bus.uop_param,  24'h000010);
        check("t2_cp_opcode", bus.uop_opcode, 8'h01);
        check("t2_cp_index",  bus.uop_index,  5'd2);
        tick();
        check("t2_cp_drop",   bus.cp_valid,   1'b0);
        check("t2_issues",    issue_log.size(), 2);

        // Overflow: six strobes, no load acceptance.
        do_reset();
        bus.ld_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(64'h0300000000000000 | 64'(i), 5'(i));
        check("t3_fifo_count", bus.fifo_count, 3'd4);
        check("t3_fifo_full",  bus.fifo_full,  1'b1);
        check("t3_err",        bus.err,        3'b001);
        check("t3_ld_valid",   bus.ld_valid,   1'b1);
        check("t3_first_idx",  bus.uop_index,  5'd0);
        bus.ld_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            check($sformatf("t3_valid_%0d", k), bus.ld_valid,  1'b1);
            check($sformatf("t3_idx_%0d", k),   bus.uop_index, 5'(k));
        end
        tick();
        check("t3_sixth_dropped", bus.ld_valid, 1'b0);

        // NOP and illegal opcode are discarded; LOAD_WEIGHT issues.
        do_reset();
        issue_log.delete();
        push(64'h0000000000000000, 5'd10);
        push(64'h7F00000000000000, 5'd11);
        push(64'h0300000000000000, 5'd12);
        repeat (4) tick();
        check("t4_issue_count", issue_log.size(), 1);
        if (issue_log.size() > 0) check("t4_issue_entry", issue_log[0], {8'h03, 5'd12});
        check("t4_err", bus.err, 3'b010);

        // END waits for the outstanding load, then stops popping.
        do_reset();
        issue_log.delete();
        push(64'h0400000001000000, 5'd1);
        push(64'hFF00000000000000, 5'd2);
        push(64'h0100000000000010, 5'd3);
        repeat (5) tick();
        check("t5_done_early", bus.done,       1'b0);
        check("t5_count_wait", bus.fifo_count, 3'd2);
        bus.ld_done = 1'b1;
        tick();
        bus.ld_done = 1'b0;
        tick();
        check("t5_done",       bus.done,       1'b1);
        check("t5_count_done", bus.fifo_count, 3'd1);
        repeat (3) tick();
        check("t5_no_cp",      bus.cp_valid,   1'b0);
        check("t5_issues",     issue_log.size(), 1);
        check("t5_count_hold", bus.fifo_count, 3'd1);

        // ld_done with nothing outstanding, then reset mid-stream.
        bus.ld_done = 1'b1;
        tick();
        bus.ld_done = 1'b0;
        check("t6_underflow", bus.err, 3'b100);
        bus.ld_ready = 1'b0;
        push(64'h0400000001000000, 5'd4);
        push(64'h0500000000000000, 5'd5);
        bus.i_instr_enable = 1'b1;
        rst = 1'b1;
        tick();
        bus.i_instr_enable = 1'b0;
        check_reset_state("midrst");
        rst = 1'b0;
        tick();
        check("post_rst_count", bus.fifo_count, 3'd0);
        check("post_rst_valid", bus.ld_valid,   1'b0);

        check("never_both_valid", both_seen, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
